midi_uart_rx_fifo: RTL

MIDI_UART_RX_FIFO -- requirements
Module: midi_uart_rx_fifo

---
 rtl/midi_uart_rx_fifo.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/midi_uart_rx_fifo.sv
// MIDI serial receiver: input synchroniser, 2-of-3 majority bit sampler,
// start/data/stop framing and a small first-word-fall-through receive FIFO.
module midi_uart_rx_fifo #(
    parameter int unsigned BYTE_W      = 8,
    parameter int unsigned MIDI_BAUD   = 31250,
    parameter int unsigned SYSCLK_F    = 48000000,
    parameter int unsigned FIFO_DEPTH  = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                               sys_clk,
    input  logic                               rst_n,
    input  logic                               MIDI_IN,
    output logic [BYTE_W-1:0]                  rd_data,
    output logic                               rd_is_status,
    output logic                               rd_valid,
    input  logic                               rd_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]    fifo_count,
    output logic                               framing_err,
    output logic                               overflow
);

    localparam int unsigned CLK_PER_BIT = SYSCLK_F / MIDI_BAUD;
    localparam int unsigned MID         = CLK_PER_BIT / 2;
    localparam int unsigned CNT_W       = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam int unsigned IDX_W       = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam int unsigned PTR_W       = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned OCC_W       = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } rx_state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rx_s;
    logic                   rx_prev;
    rx_state_t              state;
    logic [CNT_W-1:0]       bit_cnt;
    logic [IDX_W-1:0]       bit_idx;
    logic [BYTE_W-1:0]      shift_q;
    logic                   vote_a;
    logic                   vote_b;

    logic                   at_mid_lo_c;
    logic                   at_mid_c;
    logic                   at_mid_hi_c;
    logic                   at_end_c;
    logic                   majority_c;
    logic                   push_c;
    logic                   pop_c;
    logic                   full_c;
    logic                   wr_c;

    logic [BYTE_W-1:0]      mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       wr_ptr;
    logic [PTR_W-1:0]       rd_ptr;

    assign rx_s        = sync_q[SYNC_STAGES-1];
    assign at_mid_lo_c = (bit_cnt == CNT_W'(MID - 1));
    assign at_mid_c    = (bit_cnt == CNT_W'(MID));
    assign at_mid_hi_c = (bit_cnt == CNT_W'(MID + 1));
    assign at_end_c    = (bit_cnt == CNT_W'(CLK_PER_BIT - 1));
    assign majority_c  = (vote_a & vote_b) | (vote_a & rx_s) | (vote_b & rx_s);

    // A good stop-bit vote hands the assembled byte straight to the FIFO.
    assign push_c = (state == S_STOP) && at_mid_hi_c && majority_c;
    assign pop_c  = rd_valid && rd_ready;
    assign full_c = (fifo_count == OCC_W'(FIFO_DEPTH));
    assign wr_c   = push_c && (!full_c || pop_c);

    assign rd_data      = mem[rd_ptr];
    assign rd_is_status = rd_data[BYTE_W-1];

    // Metastability synchroniser; idle-high reset value hides reset release from the edge detector.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], MIDI_IN};
        end
    end

    // Frame receiver: start detection, glitch rejection, LSB-first capture, stop check.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            rx_prev     <= 1'b1;
            bit_cnt     <= '0;
            bit_idx     <= '0;
            shift_q     <= '0;
            vote_a      <= 1'b1;
            vote_b      <= 1'b1;
            framing_err <= 1'b0;
        end else begin
            rx_prev     <= rx_s;
            framing_err <= 1'b0;
            if (at_mid_lo_c) vote_a <= rx_s;
            if (at_mid_c)    vote_b <= rx_s;
            case (state)
                S_IDLE: begin
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (rx_prev && !rx_s) state <= S_START;
                end
                S_START: begin
                    // Keep counting to the end of the start window so data windows align to bit edges.
                    if (at_mid_hi_c && majority_c) begin
                        state   <= S_IDLE;
                        bit_cnt <= '0;
                    end else if (at_end_c) begin
                        state   <= S_DATA;
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_DATA: begin
                    if (at_mid_hi_c) shift_q <= {majority_c, shift_q[BYTE_W-1:1]};
                    if (at_end_c) begin
                        bit_cnt <= '0;
                        if (bit_idx == IDX_W'(BYTE_W - 1)) begin
                            state <= S_STOP;
                        end else begin
                            bit_idx <= bit_idx + IDX_W'(1);
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_STOP: begin
                    // Leave at the mid-stop vote so a start edge later in the stop bit is seen.
                    if (at_mid_hi_c) begin
                        bit_cnt <= '0;
                        if (majority_c) begin
                            state <= S_IDLE;
                        end else begin
                            framing_err <= 1'b1;
                            state       <= S_WAIT_IDLE;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end
                S_WAIT_IDLE: begin
                    bit_cnt <= '0;
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Receive FIFO: power-of-two ring, simultaneous push/pop allowed even when full.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rd_valid   <= 1'b0;
            overflow   <= 1'b0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            overflow <= push_c && full_c && !pop_c;
            if (wr_c) begin
                mem[wr_ptr] <= shift_q;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (pop_c) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({wr_c, pop_c})
                2'b10: begin
                    fifo_count <= fifo_count + OCC_W'(1);
                    rd_valid   <= 1'b1;
                end
                2'b01: begin
                    fifo_count <= fifo_count - OCC_W'(1);
                    rd_valid   <= (fifo_count != OCC_W'(1));
                end
                default: ;
            endcase
        end
    end

endmodule
